// File: rtl/cost_evaluator_if.sv
// Bundles the cost evaluator's job, permutation, cost-table and result signals.
// Latency: none (wiring only).
// Backpressure: none; the permutation source is paced by the next_perm request pulse.
interface cost_evaluator_if #(
  parameter int COST_W = 7,
  parameter int SUM_W  = 10,
  parameter int CNT_W  = 16
);
  logic              go;
  logic              perm_valid;
  logic [23:0]       perm_data;
  logic              next_perm;
  logic [2:0]        W;
  logic [2:0]        J;
  logic [COST_W-1:0] Cost;
  logic              busy;
  logic              Valid;
  logic [SUM_W-1:0]  MinCost;
  logic [CNT_W-1:0]  MatchCount;

  // Environment side: starts jobs, supplies permutations and table costs.
  modport master (
    output go, perm_valid, perm_data, Cost,
    input  next_perm, W, J, busy, Valid, MinCost, MatchCount
  );

  // Evaluator side.
  modport slave (
    input  go, perm_valid, perm_data, Cost,
    output next_perm, W, J, busy, Valid, MinCost, MatchCount
  );
endinterface

// File: rtl/cost_evaluator.sv
// Sums cost-table entries over each worker->job permutation; tracks the minimum sum and how many permutations hit it.
// Latency: go/perm latch -> W=0 next cycle, UPD 10 cycles later, Valid 11 cycles later for the last permutation.
// Backpressure: none; one permutation is requested (next_perm) only after the previous one is scored.
module cost_evaluator #(
  parameter int COST_W = 7,
  parameter int SUM_W  = 10,
  parameter int CNT_W  = 16
) (
  input  logic          clk,
  input  logic          rst,
  cost_evaluator_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAITP = 3'd1,
    FETCH = 3'd2,
    ACC   = 3'd3,
    UPD   = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Lexicographically last permutation: worker 0 -> job 7 ... worker 7 -> job 0.
  localparam logic [23:0] LAST_PERM = 24'o76543210;

  state_t           state;
  logic [23:0]      perm;
  logic [SUM_W-1:0] sum;
  logic [2:0]       k;
  logic [2:0]       k_next;
  logic             first;
  logic [2:0]       w_q;
  logic [2:0]       j_q;
  logic             next_perm_q;
  logic             busy_q;
  logic             valid_q;
  logic [SUM_W-1:0] min_cost;
  logic [CNT_W-1:0] match_count;
  logic [SUM_W-1:0] cost_ext;

  // Worker k's job index sits in the 3-bit field starting at bit 23-3k.
  function automatic logic [2:0] field_of(input logic [23:0] p, input logic [2:0] idx);
    logic [23:0] sh;
    sh = p << (3 * idx);
    return sh[23:21];
  endfunction

  assign k_next   = k + 3'd1;
  assign cost_ext = SUM_W'(bus.Cost);

  // Control FSM with all outputs and datapath registers updated on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      perm        <= '0;
      sum         <= '0;
      k           <= '0;
      first       <= 1'b1;
      w_q         <= '0;
      j_q         <= '0;
      next_perm_q <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      min_cost    <= '0;
      match_count <= '0;
    end else begin
      next_perm_q <= 1'b0;
      valid_q     <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.go) begin
            perm   <= bus.perm_data;
            sum    <= '0;
            first  <= 1'b1;
            k      <= '0;
            w_q    <= 3'd0;
            j_q    <= field_of(bus.perm_data, 3'd0);
            busy_q <= 1'b1;
            state  <= FETCH;
          end
        end
        WAITP: begin
          if (bus.perm_valid) begin
            perm  <= bus.perm_data;
            sum   <= '0;
            k     <= '0;
            w_q   <= 3'd0;
            j_q   <= field_of(bus.perm_data, 3'd0);
            state <= FETCH;
          end
        end
        FETCH: begin
          // Cost arriving now belongs to the worker addressed one cycle earlier.
          if (k != 3'd0) begin
            sum <= sum + cost_ext;
          end
          if (k == 3'd7) begin
            state <= ACC;
          end else begin
            k   <= k_next;
            w_q <= k_next;
            j_q <= field_of(perm, k_next);
          end
        end
        ACC: begin
          sum         <= sum + cost_ext;
          next_perm_q <= (perm != LAST_PERM);
          state       <= UPD;
        end
        UPD: begin
          if (first || (sum < min_cost)) begin
            min_cost    <= sum;
            match_count <= CNT_W'(1);
            first       <= 1'b0;
          end else if (sum == min_cost) begin
            if (match_count != '1) begin
              match_count <= match_count + CNT_W'(1);
            end
          end
          if (perm == LAST_PERM) begin
            valid_q <= 1'b1;
            state   <= DONE;
          end else begin
            state <= WAITP;
          end
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.W          = w_q;
  assign bus.J          = j_q;
  assign bus.next_perm  = next_perm_q;
  assign bus.busy       = busy_q;
  assign bus.Valid      = valid_q;
  assign bus.MinCost    = min_cost;
  assign bus.MatchCount = match_count;

endmodule

// File: tb/tb_cost_evaluator.sv
// Self-checking bench for cost_evaluator: cycle-level timing checks plus a result scoreboard.
// Latency: n/a (testbench).
// Backpressure: the bench acts as permutation source and answers every next_perm request.
module tb_cost_evaluator;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cost_evaluator_if bus ();

  cost_evaluator dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam logic [23:0] IDENT = 24'o01234567;
  localparam logic [23:0] FINAL = 24'o76543210;

  typedef struct {
    logic [9:0]  min_cost;
    logic [15:0] cnt;
  } res_t;

  int          checks = 0;
  int          errors = 0;
  int          valid_cnt = 0;
  res_t        exp_q[$];
  logic [23:0] job_q[$];
  logic [6:0]  cost_tab [8][8];

  logic [9:0]  m_min;
  int          m_cnt;
  bit          m_first;
  logic [9:0]  last_min;
  logic [15:0] last_cnt;

  // Synchronous cost table: Cost reflects the (W, J) pair of the previous cycle.
  always @(posedge clk) bus.Cost <= cost_tab[bus.W][bus.J];

  // Scoreboard: each Valid pulse consumes one expected job result.
  always @(negedge clk) begin
    if (!rst && bus.Valid) begin
      res_t e;
      valid_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: Valid=1 MinCost=%0d MatchCount=%0d, required no Valid",
                 bus.MinCost, bus.MatchCount);
      end else begin
        e = exp_q.pop_front();
        if (bus.MinCost !== e.min_cost || bus.MatchCount !== e.cnt) begin
          errors++;
          $display("FAIL job_result: got MinCost=%0d MatchCount=%0d, required MinCost=%0d MatchCount=%0d",
                   bus.MinCost, bus.MatchCount, e.min_cost, e.cnt);
        end
      end
    end
  end

  function automatic logic [2:0] fld(input logic [23:0] p, input int i);
    return p[23-3*i -: 3];
  endfunction

  function automatic logic [9:0] perm_sum(input logic [23:0] p);
    logic [9:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) s = s + 10'(cost_tab[i][fld(p, i)]);
    return s;
  endfunction

  function automatic logic [23:0] rand_perm();
    int a[8];
    int t, r;
    logic [23:0] p;
    do begin
      for (int i = 0; i < 8; i++) a[i] = i;
      for (int i = 7; i > 0; i--) begin
        r = int'($urandom_range(i, 0));
        t = a[i]; a[i] = a[r]; a[r] = t;
      end
      p = '0;
      for (int i = 0; i < 8; i++) p = (p << 3) | 24'(a[i]);
    end while (p == IDENT || p == FINAL);
    return p;
  endfunction

  task automatic set_cost(input int mode, input int val);
    for (int w = 0; w < 8; w++)
      for (int j = 0; j < 8; j++)
        case (mode)
          0:       cost_tab[w][j] = 7'(val);
          1:       cost_tab[w][j] = (w == j) ? 7'd1 : 7'd10;
          default: cost_tab[w][j] = 7'($urandom_range(127, 0));
        endcase
  endtask

  task automatic model_start();
    m_first = 1'b1;
    m_cnt   = 0;
    m_min   = '0;
  endtask

  task automatic model_add(input logic [23:0] p);
    logic [9:0] s;
    s = perm_sum(p);
    if (m_first || s < m_min) begin
      m_min = s; m_cnt = 1; m_first = 1'b0;
    end else if (s == m_min) begin
      m_cnt++;
    end
  endtask

  task automatic model_push();
    res_t e;
    e.min_cost = m_min;
    e.cnt      = 16'(m_cnt);
    exp_q.push_back(e);
    last_min = m_min;
    last_cnt = 16'(m_cnt);
  endtask

  // Wait (bounded) for the DUT to answer the permutation just handed over.
  task automatic wait_outcome(input bit want_valid, input int idx, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk);
      if (!want_valid && bus.next_perm) ok = 1'b1;
      if (want_valid && bus.Valid) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL job_progress: perm %0d got no %s within 40 cycles, required one",
               idx, want_valid ? "Valid" : "next_perm");
    end
  endtask

  // Run the permutations in job_q as one job; the last entry must be FINAL.
  task automatic run_job();
    bit ok;
    int last;
    last = job_q.size() - 1;
    model_start();
    @(negedge clk);
    for (int i = 0; i <= last; i++) begin
      model_add(job_q[i]);
      if (i == last) model_push();
      bus.perm_data = job_q[i];
      if (i == 0) begin
        bus.go = 1'b1;
        @(negedge clk);
        bus.go = 1'b0;
      end else begin
        @(negedge clk);
        repeat ($urandom_range(2, 0)) @(negedge clk);
        bus.perm_valid = 1'b1;
        @(negedge clk);
        bus.perm_valid = 1'b0;
      end
      wait_outcome(i == last, i, ok);
      if (!ok) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.Valid !== 1'b0 || bus.next_perm !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b Valid=%b next_perm=%b, required 0 0 0",
               bus.busy, bus.Valid, bus.next_perm);
    end
    checks++;
    if (bus.W !== 3'd0 || bus.J !== 3'd0 || bus.MinCost !== 10'd0 || bus.MatchCount !== 16'd0) begin
      errors++;
      $display("FAIL reset_data: W=%0d J=%0d MinCost=%0d MatchCount=%0d, required all 0",
               bus.W, bus.J, bus.MinCost, bus.MatchCount);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.W !== 3'd0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b W=%0d after release, required 0 0", bus.busy, bus.W);
    end
  endtask

  // Identity permutation: exact W/J/busy/next_perm timing, then finish with FINAL.
  task automatic test_latency();
    bit ok;
    set_cost(0, 5);
    model_start();
    model_add(IDENT);
    @(negedge clk);
    bus.perm_data = IDENT;
    bus.go = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      bus.go = 1'b0;
      if (c <= 8) begin
        checks++;
        if (bus.W !== 3'(c - 1) || bus.J !== 3'(c - 1)) begin
          errors++;
          $display("FAIL fetch_addr cycle %0d: W=%0d J=%0d, required W=%0d J=%0d",
                   c, bus.W, bus.J, c - 1, c - 1);
        end
      end
      checks++;
      if (bus.next_perm !== (c == 10)) begin
        errors++;
        $display("FAIL next_perm_timing cycle %0d: next_perm=%b, required %b", c, bus.next_perm, c == 10);
      end
      checks++;
      if (bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL busy cycle %0d: busy=%b, required 1", c, bus.busy);
      end
    end
    checks++;
    if (bus.W !== 3'd7 || bus.J !== 3'd7) begin
      errors++;
      $display("FAIL addr_hold: W=%0d J=%0d in WAITP, required 7 7", bus.W, bus.J);
    end
    model_add(FINAL);
    model_push();
    bus.perm_data = FINAL;
    bus.perm_valid = 1'b1;
    @(negedge clk);
    bus.perm_valid = 1'b0;
    wait_outcome(1'b1, 1, ok);
  endtask

  // Only the last permutation: no next_perm, Valid exactly at cycle 11.
  task automatic test_final_only();
    bit np_seen;
    np_seen = 1'b0;
    set_cost(0, 3);
    model_start();
    model_add(FINAL);
    model_push();
    @(negedge clk);
    bus.perm_data = FINAL;
    bus.go = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      bus.go = 1'b0;
      if (bus.next_perm) np_seen = 1'b1;
      checks++;
      if (bus.Valid !== (c == 11)) begin
        errors++;
        $display("FAIL valid_timing cycle %0d: Valid=%b, required %b", c, bus.Valid, c == 11);
      end
      checks++;
      if (bus.busy !== (c <= 11)) begin
        errors++;
        $display("FAIL busy_final cycle %0d: busy=%b, required %b", c, bus.busy, c <= 11);
      end
    end
    checks++;
    if (np_seen) begin
      errors++;
      $display("FAIL final_no_next_perm: next_perm pulsed=1, required 0");
    end
  endtask

  // perm_valid and go during FETCH must not disturb the running permutation.
  task automatic test_ignored_inputs();
    bit ok;
    set_cost(1, 0);
    model_start();
    model_add(FINAL);
    model_push();
    @(negedge clk);
    bus.perm_data = FINAL;
    bus.go = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      bus.go = 1'b0;
      bus.perm_valid = 1'b0;
      checks++;
      if (bus.J !== fld(FINAL, c - 1)) begin
        errors++;
        $display("FAIL ignored_input_J cycle %0d: J=%0d, required %0d", c, bus.J, fld(FINAL, c - 1));
      end
      if (c == 3) begin
        bus.perm_data = IDENT;
        bus.perm_valid = 1'b1;
        bus.go = 1'b1;
      end
    end
    wait_outcome(1'b1, 0, ok);
  endtask

  task automatic test_jobs();
    logic [23:0] p;
    // Uniform cost: every permutation ties at 40.
    set_cost(0, 5);
    job_q.delete();
    job_q.push_back(IDENT);
    for (int i = 0; i < 20; i++) job_q.push_back(rand_perm());
    job_q.push_back(FINAL);
    run_job();
    // Diagonal cost: only the identity reaches the minimum of 8.
    set_cost(1, 0);
    job_q.delete();
    for (int i = 0; i < 10; i++) job_q.push_back(rand_perm());
    job_q.push_back(IDENT);
    for (int i = 0; i < 5; i++) job_q.push_back(rand_perm());
    job_q.push_back(FINAL);
    run_job();
    // Random table with a repeated permutation so ties are exercised.
    set_cost(2, 0);
    job_q.delete();
    for (int i = 0; i < 12; i++) job_q.push_back(rand_perm());
    p = job_q[3];
    job_q.push_back(p);
    job_q.push_back(FINAL);
    run_job();
  endtask

  // Reset during FETCH aborts the job; the next job starts from first=1.
  task automatic test_reset_mid();
    set_cost(0, 10);
    @(negedge clk);
    bus.perm_data = FINAL;
    bus.go = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      bus.go = 1'b0;
    end
    checks++;
    if (bus.MinCost !== last_min || bus.MatchCount !== last_cnt) begin
      errors++;
      $display("FAIL result_hold: MinCost=%0d MatchCount=%0d, required %0d %0d",
               bus.MinCost, bus.MatchCount, last_min, last_cnt);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.Valid !== 1'b0 || bus.next_perm !== 1'b0 ||
        bus.W !== 3'd0 || bus.J !== 3'd0 || bus.MinCost !== 10'd0 || bus.MatchCount !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b Valid=%b next_perm=%b W=%0d J=%0d MinCost=%0d MatchCount=%0d, required all 0",
               bus.busy, bus.Valid, bus.next_perm, bus.W, bus.J, bus.MinCost, bus.MatchCount);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: busy=%b after aborted job, required 0", bus.busy);
    end
    job_q.delete();
    job_q.push_back(FINAL);
    run_job();
  endtask

  initial begin
    bus.go = 1'b0;
    bus.perm_valid = 1'b0;
    bus.perm_data = '0;
    set_cost(0, 0);
    last_min = '0;
    last_cnt = '0;
    test_reset();
    test_latency();
    test_final_only();
    test_ignored_inputs();
    test_jobs();
    test_reset_mid();
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || valid_cnt != 7) begin
      errors++;
      $display("FAIL valid_count: %0d Valid pulses with %0d results pending, required 7 and 0",
               valid_cnt, exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
